// File: rtl/operand_issuer_pkg.sv
// Shared defaults and the operand-pair layout for the operand issuer slice.
package operand_issuer_pkg;
    localparam int OI_W     = 10;
    localparam int OI_DEPTH = 4;

    // Field a occupies the upper half when the pair is flattened into FIFO storage.
    typedef struct packed {
        logic [OI_W-1:0] a;
        logic [OI_W-1:0] b;
    } operand_pair_t;
endpackage

// File: rtl/operand_issuer_if.sv
// Upstream operand handshake, issue throttle and adder-facing outputs of the issuer.
interface operand_issuer_if
    import operand_issuer_pkg::*;
#(
    parameter int W = OI_W
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         issue_en;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic [15:0]  issued_cnt;

    modport master (
        output in_valid, in_a, in_b, issue_en,
        input  in_ready, start, a, b, busy, issued_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, issue_en,
        output in_ready, start, a, b, busy, issued_cnt
    );
endinterface

// File: rtl/operand_fifo.sv
// Operand-pair FIFO; registered head, no write-to-read bypass.
// Push ignored when full, pop ignored when empty.
module operand_fifo
    import operand_issuer_pkg::*;
#(
    parameter int W     = OI_W,
    parameter int DEPTH = OI_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [2*W-1:0]               i_dat,
    input  logic                         i_pop,
    output logic [2*W-1:0]               o_dat,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [2*W-1:0] r_mem [DEPTH];
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end
endmodule

// File: rtl/operand_issuer.sv
// Queues operand pairs and issues start+A, then B one cycle later; start/a 2 cycles after accept.
// in_ready drops only when the FIFO is full; issue_en low freezes the queue.
module operand_issuer
    import operand_issuer_pkg::*;
#(
    parameter int W     = OI_W,
    parameter int DEPTH = OI_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    operand_issuer_if.slave   bus
);
    localparam int CW = $clog2(DEPTH+1);

    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [2*W-1:0] w_head;
    logic [W-1:0]   w_head_a;
    logic [W-1:0]   w_head_b;

    logic           r_start;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_pend_b;
    logic           r_pend_v;
    logic [15:0]    r_issued_cnt;

    assign w_push   = bus.in_valid && bus.in_ready;
    assign w_pop    = !w_empty && bus.issue_en;
    assign w_head_a = w_head[2*W-1:W];
    assign w_head_b = w_head[W-1:0];

    operand_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   ({bus.in_a, bus.in_b}),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // B is held one cycle so it lines up with the adder's delayed copy of A.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_pend_b     <= '0;
            r_pend_v     <= 1'b0;
            r_issued_cnt <= '0;
        end else begin
            r_b <= r_pend_v ? r_pend_b : '0;
            if (w_pop) begin
                r_start      <= 1'b1;
                r_a          <= w_head_a;
                r_pend_b     <= w_head_b;
                r_pend_v     <= 1'b1;
                r_issued_cnt <= r_issued_cnt + 16'd1;
            end else begin
                r_start  <= 1'b0;
                r_a      <= '0;
                r_pend_v <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.start      = r_start;
    assign bus.a          = r_a;
    assign bus.b          = r_b;
    assign bus.busy       = (w_count != '0) || r_start || r_pend_v;
    assign bus.issued_cnt = r_issued_cnt;
endmodule

// File: tb/tb_operand_issuer.sv
// Directed bench for operand_issuer with a behavioural a_d + b adder downstream.
module tb_operand_issuer;
    import operand_issuer_pkg::*;

    localparam int W     = OI_W;
    localparam int DEPTH = OI_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    operand_issuer_if #(.W(W)) bus ();

    operand_issuer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Downstream adder: registers A with start, adds B next cycle, y/valid one cycle later.
    logic [W-1:0] ad_a = '0;
    logic [W-1:0] ad_y = '0;
    logic         ad_s = 1'b0;
    logic         ad_v = 1'b0;
    always @(posedge clk) begin
        ad_a <= bus.a;
        ad_s <= bus.start;
        ad_v <= ad_s;
        ad_y <= ad_a + bus.b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.in_valid = v;
        bus.in_a     = x;
        bus.in_b     = y;
    endtask

    function automatic operand_pair_t mk(input int x, input int y);
        operand_pair_t p;
        p.a = W'(x);
        p.b = W'(y);
        return p;
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        bus.issue_en = 1'b0;
        drive(1'b0, '0, '0);
        step();
        check("rst start", bus.start, 0);
        check("rst a", bus.a, 0);
        check("rst b", bus.b, 0);
        check("rst cnt", bus.issued_cnt, 0);
        rst = 1'b0;
        step();
        check("post-rst in_ready", bus.in_ready, 1);
        check("post-rst busy", bus.busy, 0);
    endtask

    operand_pair_t p2 [4];
    operand_pair_t p3 [5];
    int            y2 [4];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.issue_en = 1'b0;
        step();

        // Single pair (3,5)
        do_reset();
        bus.issue_en = 1'b1;
        check("t1 in_ready", bus.in_ready, 1);
        drive(1'b1, 10'd3, 10'd5);
        step();
        drive(1'b0, '0, '0);
        check("t1 c1 start", bus.start, 0);
        check("t1 c1 busy", bus.busy, 1);
        step();
        check("t1 c2 start", bus.start, 1);
        check("t1 c2 a", bus.a, 3);
        check("t1 c2 b", bus.b, 0);
        step();
        check("t1 c3 start", bus.start, 0);
        check("t1 c3 a", bus.a, 0);
        check("t1 c3 b", bus.b, 5);
        step();
        check("t1 c4 valid", ad_v, 1);
        check("t1 c4 y", ad_y, 8);
        check("t1 cnt", bus.issued_cnt, 1);

        // Four back-to-back pairs
        p2[0] = mk(1, 2); p2[1] = mk(3, 4); p2[2] = mk(5, 6); p2[3] = mk(7, 8);
        y2[0] = 3; y2[1] = 7; y2[2] = 11; y2[3] = 15;
        do_reset();
        bus.issue_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("t2 start", bus.start, (i >= 2 && i <= 5) ? 1 : 0);
            if (i >= 2 && i <= 5) check("t2 a", bus.a, p2[i-2].a);
            else                  check("t2 a idle", bus.a, 0);
            if (i >= 3 && i <= 6) check("t2 b", bus.b, p2[i-3].b);
            else                  check("t2 b idle", bus.b, 0);
            check("t2 valid", ad_v, (i >= 4 && i <= 7) ? 1 : 0);
            if (i >= 4 && i <= 7) check("t2 y", ad_y, y2[i-4]);
            check("t2 in_ready", bus.in_ready, 1);
            if (i < 4) drive(1'b1, p2[i].a, p2[i].b);
            else       drive(1'b0, '0, '0);
            step();
        end
        check("t2 cnt", bus.issued_cnt, 4);
        check("t2 busy", bus.busy, 0);

        // Fill with issue_en low, fifth pair held until a pop
        p3[0] = mk(11, 12); p3[1] = mk(13, 14); p3[2] = mk(15, 16);
        p3[3] = mk(17, 18); p3[4] = mk(19, 20);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("t3 in_ready fill", bus.in_ready, 1);
            drive(1'b1, p3[i].a, p3[i].b);
            step();
        end
        check("t3 full in_ready", bus.in_ready, 0);
        check("t3 full busy", bus.busy, 1);
        drive(1'b1, p3[4].a, p3[4].b);
        step();
        check("t3 held in_ready", bus.in_ready, 0);
        check("t3 frozen start", bus.start, 0);
        bus.issue_en = 1'b1;
        step();
        for (int i = 6; i < 12; i++) begin
            if (i == 6) check("t3 ready after pop", bus.in_ready, 1);
            if (i == 7) drive(1'b0, '0, '0);
            check("t3 start", bus.start, (i <= 10) ? 1 : 0);
            if (i <= 10) check("t3 a", bus.a, p3[i-6].a);
            if (i >= 7)  check("t3 b", bus.b, p3[i-7].b);
            step();
        end
        check("t3 cnt", bus.issued_cnt, 5);

        // issue_en dropped the cycle after a pop
        do_reset();
        bus.issue_en = 1'b1;
        drive(1'b1, 10'd21, 10'd22);
        step();
        drive(1'b1, 10'd23, 10'd24);
        step();
        drive(1'b0, '0, '0);
        bus.issue_en = 1'b0;
        check("t4 c2 start", bus.start, 1);
        check("t4 c2 a", bus.a, 21);
        step();
        check("t4 c3 start", bus.start, 0);
        check("t4 c3 b", bus.b, 22);
        check("t4 c3 busy", bus.busy, 1);
        step();
        check("t4 c4 start", bus.start, 0);
        check("t4 c4 b", bus.b, 0);
        bus.issue_en = 1'b1;
        step();
        check("t4 c5 start", bus.start, 1);
        check("t4 c5 a", bus.a, 23);
        step();
        check("t4 c6 b", bus.b, 24);
        check("t4 cnt", bus.issued_cnt, 2);

        // Reset with three queued and a pending B
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(31 + 2*i), W'(32 + 2*i));
            step();
        end
        drive(1'b0, '0, '0);
        bus.issue_en = 1'b1;
        step();
        check("t5 start", bus.start, 1);
        check("t5 a", bus.a, 31);
        rst          = 1'b1;
        bus.issue_en = 1'b0;
        step();
        check("t5 rst start", bus.start, 0);
        check("t5 rst a", bus.a, 0);
        check("t5 rst b", bus.b, 0);
        check("t5 rst cnt", bus.issued_cnt, 0);
        check("t5 rst busy", bus.busy, 0);
        check("t5 rst in_ready", bus.in_ready, 1);
        rst          = 1'b0;
        bus.issue_en = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("t5 no stale start", bus.start, 0);
            check("t5 no stale b", bus.b, 0);
            check("t5 idle busy", bus.busy, 0);
            step();
        end

        // Bit-exact pass-through and adder wrap
        do_reset();
        bus.issue_en = 1'b1;
        drive(1'b1, 10'h3FF, 10'h001);
        step();
        drive(1'b0, '0, '0);
        step();
        check("t6 a", bus.a, 32'h3FF);
        step();
        check("t6 b", bus.b, 32'h001);
        step();
        check("t6 valid", ad_v, 1);
        check("t6 y wrap", ad_y, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/operand_issuer.md
OPERAND_ISSUER -- requirements
Module: operand_issuer

Interface
REQ-001 Parameter W, default 10: operand width, equal to the W of the downstream adder stage.
REQ-002 Parameter DEPTH, default 4: operand FIFO depth; power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  upstream operand pair valid.
REQ-006 in_ready  out  1  issuer can accept a pair this cycle.
REQ-007 in_a  in  W  operand A of the offered pair.
REQ-008 in_b  in  W  operand B of the offered pair.
REQ-009 issue_en  in  1  permit issuing from FIFO this cycle (downstream throttle).
REQ-010 start  out  1  to adder start; registered.
REQ-011 a  out  W  to adder a; registered; meaningful in the start cycle.
REQ-012 b  out  W  to adder b; registered; meaningful in the cycle after start.
REQ-013 busy  out  1  FIFO non-empty, or start high, or B delivery pending.
REQ-014 issued_cnt  out  16  count of issued pairs.

Function
REQ-015 Accept: a pair SHALL be written when in_valid && in_ready; in_ready SHALL be (count < DEPTH), independent of in_valid and of a same-cycle pop.
REQ-016 Pop: in any cycle with FIFO non-empty && issue_en, the head entry SHALL be popped.
REQ-017 On the edge ending a pop cycle: start<=1, a<=head.a, pend_b<=head.b, pend_v<=1; otherwise start<=0, a<=0, pend_v<=0.
REQ-018 On every edge: b<=pend_v ? pend_b : 0, so B of a pair appears exactly one cycle after its start/A, which is the adder's a_d + b alignment.
REQ-019 Back-to-back issue SHALL be supported: with continuous pops, cycle N carries start=1, A of pair k and B of pair k-1.
REQ-020 Latency: accept in cycle 0, pop earliest cycle 1, start/a visible cycle 2, b visible cycle 3; adder valid/y visible cycle 4.
REQ-021 No bypass: a pair written into an empty FIFO SHALL NOT be popped in its write cycle.
REQ-022 Simultaneous push and pop SHALL both occur (non-full case); count unchanged.
REQ-023 Full: in_ready=0; offered pair ignored; upstream holds it.
REQ-024 issue_en low SHALL freeze the FIFO; a pending B from the previous pop SHALL still be delivered.
REQ-025 FIFO order SHALL be preserved; pointers wrap modulo DEPTH.
REQ-026 issued_cnt SHALL increment by 1 on each pop and wrap 16'hFFFF -> 0.
REQ-027 The block SHALL perform no arithmetic on operand data; values pass through bit-exact.

Reset
REQ-028 While rst is sampled high: FIFO count and pointers 0, pend_v 0, pend_b 0, start 0, a 0, b 0, issued_cnt 0.
REQ-029 in_ready SHALL be 1 and busy 0 in the cycle after reset is released.
REQ-030 Reset mid-operation SHALL discard queued pairs and any pending B; no start occurs until new pairs are accepted.

Structure
REQ-031 Package operand_issuer_pkg SHALL hold the W and DEPTH defaults and the operand-pair struct typedef {a, b}.
REQ-032 The FIFO SHALL be a sub-module operand_fifo (parameters W, DEPTH; push/pop, full/empty, count of width clog2(DEPTH+1)).
REQ-033 Issue and B-delay logic SHALL reside in operand_issuer; the FIFO storage itself needs no reset.

Verification
REQ-034 Single pair (3,5), issue_en=1 -> start=1 with a=3 in cycle 2, b=5 in cycle 3; chained adder shows valid=1 with y=8 in cycle 4.
REQ-035 Four back-to-back pairs (1,2),(3,4),(5,6),(7,8) -> four consecutive start pulses; adder y sequence 3,7,11,15; issued_cnt=4.
REQ-036 Fill with issue_en=0 -> in_ready=0 after 4 accepts; fifth pair held until a pop occurs; pair order preserved.
REQ-037 issue_en dropped the cycle after a pop -> that pair's b still delivered next cycle; no further start while low.
REQ-038 rst asserted with 3 queued and pending B -> all outputs 0 next cycle, busy=0, no stale start after release.
REQ-039 Operands 10'h3FF,10'h001 -> pass through unaltered; adder y wraps to 0.
